// File: rtl/display_pkg.sv
// Shared types and constants for the serial display shift-register driver.
package display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_e;

    localparam int DEF_NUM_DIGITS = 6;
    localparam int DEF_SEG_WIDTH  = 8;

    // Wide enough for any practical SEG_WIDTH; users slice the low bits.
    localparam logic [63:0] SEG_ALL_OFF = '0;

endpackage

// File: rtl/sr_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled, tick on the last count.
module sr_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/sr_display_driver.sv
// Fetches digit patterns, shifts them MSB-first into an external
// shift-register chain and latches the whole frame at once.
module sr_display_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SEG_WIDTH  = DEF_SEG_WIDTH,
    parameter int CLK_DIV    = 4,
    parameter int ACTIVE_LOW = 0,
    parameter int SEL_WIDTH  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 blank,
    input  logic [SEG_WIDTH-1:0] seg_data,
    output logic [SEL_WIDTH-1:0] digit_sel,
    output logic                 sr_data,
    output logic                 sr_clk,
    output logic                 sr_latch,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(SEG_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(SEG_WIDTH - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_DIGIT = SEL_WIDTH'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    state_e               state_q;
    logic [SEG_WIDTH-1:0] shreg_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [SEL_WIDTH-1:0] digit_sel_q;
    logic                 sr_data_q;
    logic                 sr_clk_q;
    logic                 sr_latch_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;
    logic [SEG_WIDTH-1:0] load_val;
    logic [SEG_WIDTH-1:0] shifted;

    sr_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == ST_IDLE),
        .tick_o  (tick)
    );

    assign load_val = blank ? SEG_ALL_OFF[SEG_WIDTH-1:0] : seg_data;
    assign shifted  = {shreg_q[SEG_WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            digit_sel_q <= '0;
            sr_data_q   <= 1'b0;
            sr_clk_q    <= 1'b0;
            sr_latch_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start || continuous) begin
                        state_q     <= ST_LOAD;
                        digit_sel_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        shreg_q   <= load_val;
                        bit_cnt_q <= '0;
                        sr_data_q <= load_val[SEG_WIDTH-1] ^ POL;
                        state_q   <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        sr_clk_q <= 1'b1;
                        state_q  <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        shreg_q   <= shifted;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        sr_clk_q  <= 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            sr_data_q <= shifted[SEG_WIDTH-1] ^ POL;
                            state_q   <= ST_SHIFT_LO;
                        end else if (digit_sel_q != LAST_DIGIT) begin
                            digit_sel_q <= digit_sel_q + 1'b1;
                            state_q     <= ST_LOAD;
                        end else begin
                            sr_latch_q <= 1'b1;
                            state_q    <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        sr_latch_q  <= 1'b0;
                        done_q      <= 1'b1;
                        digit_sel_q <= '0;
                        if (continuous) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign digit_sel = digit_sel_q;
    assign sr_data   = sr_data_q;
    assign sr_clk    = sr_clk_q;
    assign sr_latch  = sr_latch_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
